mips_mc_sequencer: RTL

MIPS_MC_SEQUENCER -- requirements
Module: mips_mc_sequencer

---
 rtl/mips_mc_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle MIPS control sequencer: walks each instruction through fetch, decode,
// execute, memory, addm and write-back steps over one shared memory port with a bus timeout.
module mips_mc_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        except,
  input  logic [1:0]  control_type,
  input  logic        writeenable,
  input  logic        mem_read,
  input  logic        word_we,
  input  logic        byte_we,
  input  logic        addm,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_fetch,
  output logic        mem_we,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        addm_phase,
  output logic [2:0]  state,
  output logic        exc,
  output logic        bus_err,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_ADDM_EX = 3'd4,
    S_WB      = 3'd5,
    S_EXC     = 3'd6,
    S_BAD     = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_wait;
  logic        r_bus_err;
  logic [15:0] r_retired;
  logic        w_retire;
  logic        w_timeout;
  logic        w_memop;
  logic        w_store;
  logic        w_unused_ctl;

  // Branch/jump/jr all retire identically here; the PC source is chosen in the datapath.
  assign w_unused_ctl = ^control_type;

  assign w_memop = mem_read | word_we | byte_we | addm;
  assign w_store = word_we | byte_we;

  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_fetch  = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    addm_phase = 1'b0;
    w_retire   = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_fetch = 1'b1;
        if (mem_ready) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end else if (r_wait == 4'hF) begin
          w_timeout = 1'b1;
          w_next    = S_EXC;
        end
      end
      S_DECODE: w_next = except ? S_EXC : S_EXEC;
      S_EXEC: begin
        if (w_memop) begin
          w_next = S_MEM;
        end else if (writeenable) begin
          w_next = S_WB;
        end else begin
          pc_we    = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = w_store;
        if (mem_ready) begin
          if (w_store) begin
            pc_we    = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            mdr_we = 1'b1;
            w_next = addm ? S_ADDM_EX : S_WB;
          end
        end else if (r_wait == 4'hF) begin
          w_timeout = 1'b1;
          w_next    = S_EXC;
        end
      end
      S_ADDM_EX: begin
        addm_phase = 1'b1;
        w_next     = S_WB;
      end
      S_WB: begin
        rf_we    = 1'b1;
        pc_we    = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_EXC:   w_next = S_EXC;
      default: w_next = S_EXC;
    endcase
    // Reset abandons whatever is in flight: no strobe may escape on the reset cycle.
    if (reset) begin
      mem_req    = 1'b0;
      mem_fetch  = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      mdr_we     = 1'b0;
      pc_we      = 1'b0;
      rf_we      = 1'b0;
      addm_phase = 1'b0;
      w_retire   = 1'b0;
      w_timeout  = 1'b0;
      w_next     = S_FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_wait    <= 4'd0;
      r_bus_err <= 1'b0;
      r_retired <= 16'd0;
    end else begin
      r_state <= w_next;
      if ((w_next == S_FETCH || w_next == S_MEM) && (w_next != r_state)) begin
        r_wait <= 4'd0;
      end else if (mem_req && !mem_ready && (r_wait != 4'hF)) begin
        r_wait <= r_wait + 4'd1;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
      if (w_retire) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  assign state   = r_state;
  assign exc     = (r_state == S_EXC);
  assign bus_err = r_bus_err;
  assign retired = r_retired;

endmodule
